// File: rtl/slr_crossing_fifo.sv
// Parametrised FWFT synchronous FIFO for inter-SLR valid/ready crossings.
// Define SLR_FIFO_REG_READY_EN for a registered enq_ready with AF_MARGIN skid entries.
module slr_crossing_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DATA_W-1:0]          enq_bits,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [DATA_W-1:0]          deq_bits,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if ((DEPTH < 4) || ((1 << PTR_W) != DEPTH)) begin : g_depth_chk
    $error("slr_crossing_fifo: DEPTH must be a power of two >= 4");
  end
  if ((AF_MARGIN < 1) || (AF_MARGIN > DEPTH - 2)) begin : g_margin_chk
    $error("slr_crossing_fifo: AF_MARGIN must be in 1..DEPTH-2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              overflow_q;
  logic              full;
  logic              empty;
  logic              enq_fire;
  logic              deq_fire;

  // Acceptance uses true occupancy so beats in flight behind a registered ready survive.
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    enq_fire  = enq_valid && !full && !flush;
    deq_fire  = deq_ready && !empty && !flush;
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      count_nxt = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      // No full-bypass: a beat offered while full is lost even if the head leaves.
      if (enq_valid && full) overflow_q <= 1'b1;
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clock) begin
    if (reset && enq_fire) mem[wr_ptr] <= enq_bits;
  end

  assign deq_valid = !empty;
  assign deq_bits  = empty ? '0 : mem[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef SLR_FIFO_REG_READY_EN
  logic enq_ready_q;

  // Looks at next occupancy so ready drops on the same edge the threshold is reached.
  always_ff @(posedge clock) begin
    if (!reset) begin
      enq_ready_q <= 1'b1;
    end else if (flush) begin
      enq_ready_q <= 1'b1;
    end else begin
      enq_ready_q <= (count_nxt < CNT_W'(DEPTH - AF_MARGIN));
    end
  end

  assign enq_ready = enq_ready_q;
`else
  assign enq_ready = !full;
`endif

endmodule
